// File: rtl/pe_ctrl_pkg.sv
// Shared state encoding, latched-config layout and parameter defaults
// for the convolution PE sequencer.
package pe_ctrl_pkg;

    localparam int unsigned ADR_W_DEF = 8;
    localparam int unsigned SLOTS_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StMac,
        StDrain,
        StStore,
        StWrite,
        StFlush,
        StDone
    } pe_ctrl_state_t;

    typedef struct packed {
        logic [7:0] filter_len;
        logic [7:0] num_windows;
        logic [7:0] stride;
    } pe_ctrl_cfg_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Image/filter address generator: window base, tap index k, and the
// one-cycle acc_en delay that lines up with buffer read data.
module conv_addr_gen
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ADR_W = ADR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             clr_k,
    input  logic             inc_k,
    input  logic             issue,
    input  logic             mac,
    input  logic [7:0]       stride,
    output logic [7:0]       k,
    output logic [ADR_W-1:0] img_adr,
    output logic [ADR_W-1:0] filt_adr,
    output logic             acc_en
);

    logic [ADR_W-1:0] base_q, base_d;
    logic [7:0]       k_q, k_d;
    logic             acc_en_q;

    always_comb begin
        base_d = base_q;
        k_d    = k_q;
        if (load) begin
            base_d = '0;
        end else if (step) begin
            base_d = base_q + ADR_W'(stride);
        end
        if (load || clr_k) begin
            k_d = '0;
        end else if (inc_k) begin
            k_d = k_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            k_q      <= '0;
            acc_en_q <= 1'b0;
        end else begin
            base_q   <= base_d;
            k_q      <= k_d;
            // Buffers have one cycle of read latency.
            acc_en_q <= mac;
        end
    end

    assign k        = k_q;
    assign img_adr  = issue ? base_q + ADR_W'(k_q) : '0;
    assign filt_adr = issue ? ADR_W'(k_q) : '0;
    assign acc_en   = acc_en_q;

endmodule

// File: rtl/pe_controller.sv
// Sequencer for one convolution PE: walks output windows, drives MAC strobes and
// commits packed result words to PE output memory, then fires the dump strobe.
module pe_controller
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ADR_W        = ADR_W_DEF,
    parameter int unsigned SLOTS        = SLOTS_DEF,
    parameter int unsigned MAX_MEM_SIZE = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       filter_len,
    input  logic [7:0]       num_windows,
    input  logic [7:0]       stride,
    output logic             busy,
    output logic             done,
    output logic [ADR_W-1:0] img_adr,
    output logic [ADR_W-1:0] filt_adr,
    output logic             rst_acc,
    output logic             acc_en,
    output logic             rst_res_reg,
    output logic             res_buffer_en,
    output logic [7:0]       res_index,
    output logic             wr_en,
    output logic [7:0]       wr_adr,
    output logic             wr_file
);

    pe_ctrl_state_t state_q, state_d;
    pe_ctrl_cfg_t   cfg_q, cfg_d;
    logic [7:0]     win_cnt_q, win_cnt_d;
    logic [7:0]     slot_q, slot_d;
    logic [7:0]     word_adr_q, word_adr_d;

    logic       ag_load, ag_step, ag_clr_k, ag_inc_k, ag_issue, ag_mac;
    logic [7:0] k;
    logic       last_win, k_last;

    assign last_win = (win_cnt_q == cfg_q.num_windows - 8'd1);
    assign k_last   = (k == cfg_q.filter_len - 8'd1);

    conv_addr_gen #(
        .ADR_W(ADR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (ag_load),
        .step    (ag_step),
        .clr_k   (ag_clr_k),
        .inc_k   (ag_inc_k),
        .issue   (ag_issue),
        .mac     (ag_mac),
        .stride  (cfg_q.stride),
        .k       (k),
        .img_adr (img_adr),
        .filt_adr(filt_adr),
        .acc_en  (acc_en)
    );

    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        win_cnt_d     = win_cnt_q;
        slot_d        = slot_q;
        word_adr_d    = word_adr_q;
        ag_load       = 1'b0;
        ag_step       = 1'b0;
        ag_clr_k      = 1'b0;
        ag_inc_k      = 1'b0;
        ag_issue      = 1'b0;
        ag_mac        = 1'b0;
        done          = 1'b0;
        rst_acc       = 1'b0;
        rst_res_reg   = 1'b0;
        res_buffer_en = 1'b0;
        res_index     = '0;
        wr_en         = 1'b0;
        wr_adr        = '0;
        wr_file       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cfg_d      = '{filter_len: filter_len, num_windows: num_windows,
                                   stride: stride};
                    win_cnt_d  = '0;
                    slot_d     = '0;
                    word_adr_d = '0;
                    ag_load    = 1'b1;
                    state_d    = (num_windows == 8'd0 || filter_len == 8'd0) ? StFlush : StClr;
                end
            end
            StClr: begin
                rst_acc     = 1'b1;
                // A new result word starts with a clean register, so a partial
                // final word leaves its unused slots at zero.
                rst_res_reg = (slot_q == 8'd0);
                ag_issue    = 1'b1;
                state_d     = StMac;
            end
            StMac: begin
                ag_issue = 1'b1;
                ag_mac   = 1'b1;
                if (k_last) begin
                    ag_clr_k = 1'b1;
                    state_d  = StDrain;
                end else begin
                    ag_inc_k = 1'b1;
                end
            end
            StDrain: begin
                state_d = StStore;
            end
            StStore: begin
                res_buffer_en = 1'b1;
                res_index     = slot_q;
                slot_d        = slot_q + 8'd1;
                if (slot_q == 8'(SLOTS - 1) || last_win) begin
                    state_d = StWrite;
                end else begin
                    ag_step   = 1'b1;
                    win_cnt_d = win_cnt_q + 8'd1;
                    state_d   = StClr;
                end
            end
            StWrite: begin
                wr_en      = 1'b1;
                wr_adr     = word_adr_q;
                word_adr_d = (word_adr_q == 8'(MAX_MEM_SIZE - 1)) ? '0 : word_adr_q + 8'd1;
                slot_d     = '0;
                if (last_win) begin
                    state_d = StFlush;
                end else begin
                    ag_step   = 1'b1;
                    win_cnt_d = win_cnt_q + 8'd1;
                    state_d   = StClr;
                end
            end
            StFlush: begin
                wr_file = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cfg_q      <= '0;
            win_cnt_q  <= '0;
            slot_q     <= '0;
            word_adr_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            win_cnt_q  <= win_cnt_d;
            slot_q     <= slot_d;
            word_adr_q <= word_adr_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_pe_controller.sv
// Randomized bench: a behavioural PE with image/filter buffers runs under the
// sequencer and committed words are compared with directly computed convolutions.
module tb_pe_controller;

    localparam int unsigned SLOTS = 4;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] filter_len, num_windows, stride;
    logic       busy, done, rst_acc, acc_en, rst_res_reg, res_buffer_en, wr_en, wr_file;
    logic [7:0] img_adr, filt_adr, res_index, wr_adr;

    always #5 clk = ~clk;

    pe_controller #(
        .ADR_W       (8),
        .SLOTS       (SLOTS),
        .MAX_MEM_SIZE(128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .filter_len   (filter_len),
        .num_windows  (num_windows),
        .stride       (stride),
        .busy         (busy),
        .done         (done),
        .img_adr      (img_adr),
        .filt_adr     (filt_adr),
        .rst_acc      (rst_acc),
        .acc_en       (acc_en),
        .rst_res_reg  (rst_res_reg),
        .res_buffer_en(res_buffer_en),
        .res_index    (res_index),
        .wr_en        (wr_en),
        .wr_adr       (wr_adr),
        .wr_file      (wr_file)
    );

    // Behavioural PE: buffers with 1-cycle read latency, MAC, result register.
    int unsigned img_mem [256];
    int unsigned filt_mem[256];
    int unsigned img_d, filt_d, acc;
    int unsigned res[SLOTS];

    always @(posedge clk) begin
        img_d  <= img_mem[img_adr];
        filt_d <= filt_mem[filt_adr];
        if (rst || rst_acc) acc <= 0;
        else if (acc_en) acc <= acc + img_d * filt_d;
        if (rst || rst_res_reg) begin
            for (int i = 0; i < SLOTS; i++) res[i] <= 0;
        end else if (res_buffer_en && res_index < SLOTS) begin
            res[res_index] <= acc;
        end
    end

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks_total++;
        if (got == exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint outs();
        return longint'({busy, done, img_adr, filt_adr, rst_acc, acc_en, rst_res_reg,
                         res_buffer_en, res_index, wr_en, wr_adr, wr_file});
    endfunction

    function automatic int unsigned conv(input int w, input int fl, input int st);
        int unsigned sum = 0;
        for (int k = 0; k < fl; k++) sum += img_mem[(w * st + k) % 256] * filt_mem[k];
        return sum;
    endfunction

    task automatic run_one(input int fl, input int nw, input int st, input bit poke);
        int c = 1, done_cyc = 0, file_cyc = 0, last_wr_cyc = 0;
        int acc_cnt = 0, file_cnt = 0, excl_bad = 0, exp_words, exp_lat, w;
        int unsigned wadr[$];
        int unsigned wdat[$];
        bit seen_done = 0, empty_run;
        @(negedge clk);
        start = 1; filter_len = 8'(fl); num_windows = 8'(nw); stride = 8'(st);
        while (!seen_done && c < 5000) begin
            if (acc_en) acc_cnt++;
            if (int'(rst_acc) + int'(acc_en) + int'(res_buffer_en) + int'(wr_en)
                + int'(wr_file) > 1) excl_bad++;
            if (wr_en) begin
                wadr.push_back(wr_adr);
                for (int i = 0; i < SLOTS; i++) wdat.push_back(res[i]);
                last_wr_cyc = c;
            end
            if (wr_file) begin file_cnt++; file_cyc = c; end
            if (done) begin seen_done = 1; done_cyc = c; end
            if (!seen_done) begin
                @(negedge clk);
                c++;
                // Config pins carry junk once the run is latched.
                start       = poke && (c == 2);
                filter_len  = 8'($urandom);
                num_windows = 8'($urandom);
                stride      = 8'($urandom);
            end
        end
        check("done_seen", seen_done, 1);

        empty_run = (nw == 0 || fl == 0);
        exp_words = empty_run ? 0 : (nw + SLOTS - 1) / SLOTS;
        exp_lat   = empty_run ? 3 : nw * (fl + 3) + exp_words + 3;
        check("latency", done_cyc, exp_lat);
        check("num_writes", wadr.size(), exp_words);
        for (int j = 0; j < wadr.size() && j < exp_words; j++) begin
            check("wr_adr", wadr[j], j);
            for (int s = 0; s < SLOTS; s++) begin
                w = j * SLOTS + s;
                check($sformatf("word%0d_slot%0d", j, s), wdat[j * SLOTS + s],
                      (w < nw) ? conv(w, fl, st) : 0);
            end
        end
        check("acc_en_count", acc_cnt, empty_run ? 0 : nw * fl);
        check("wr_file_count", file_cnt, 1);
        check("wr_file_before_done", file_cyc, done_cyc - 1);
        if (exp_words > 0) check("wr_file_after_last_wr", file_cyc, last_wr_cyc + 1);
        check("strobe_exclusive", excl_bad, 0);

        // A start seen in DONE must not launch a run.
        start = poke;
        @(negedge clk);
        start = 0;
        check("idle_after_done", busy, 0);
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
    endtask

    task automatic reset_abort();
        int ev = 0;
        @(negedge clk);
        start = 1; filter_len = 8'd4; num_windows = 8'd8; stride = 8'd3;
        @(negedge clk);
        start = 0;
        // Cycle 11 is the second MAC cycle of window 2.
        repeat (9) @(negedge clk);
        check("mac_before_reset", acc_en, 1);
        rst = 1;
        @(negedge clk);
        check("reset_abort_outputs", outs(), 0);
        rst = 0;
        repeat (12) begin
            @(negedge clk);
            ev += int'(wr_en) + int'(wr_file) + int'(done) + int'(busy);
        end
        check("no_events_after_abort", ev, 0);
    endtask

    initial begin
        rst = 1; start = 0; filter_len = 0; num_windows = 0; stride = 0;
        for (int i = 0; i < 256; i++) begin
            img_mem[i]  = $urandom_range(1, 15);
            filt_mem[i] = $urandom_range(1, 15);
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 0;
        @(negedge clk);
        check("idle_after_reset", outs(), 0);

        run_one(3, 4, 1, 0);
        run_one(2, 5, 2, 1);
        run_one(5, 0, 3, 0);
        run_one(8, 3, 125, 1);
        run_one(0, 6, 1, 0);
        run_one(1, 9, 255, 1);
        reset_abort();
        run_one(3, 5, 7, 0);
        for (int r = 0; r < 12; r++) begin
            run_one($urandom_range(0, 12), $urandom_range(0, 20), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
